req_4_2_encoder: RTL
====================

// Module: req_4_2_encoder
// PURPOSE
//  Inverse of the team's 2->4 decoder: collects 4 request lines, queues them as pending bits, emits each as a 2-bit code.
//  Encoded output is a registered valid/ready stream, one code per accepted handshake.
//  Sits on ui_in[3:0] -> uo_out[2:0] (valid + code) of the tile wrapper; ready comes from ui_in[4].
// PARAMETERS
//  REQ_W      4  number of request lines (fixed 4; code width 2)
//  CNT_W      8  width of saturating merge counter
//  EDGE_MODE  1  1: capture on rising edge of req_i; 0: capture while req_i level high
// PORTS
//  clk          in   1      clock, all flops on rising edge
//  rst          in   1      asynchronous, active-high reset
//  req_i        in   4      request lines, one per code value (bit k -> code k)
//  ready_i      in   1      consumer accepts code_o when ready_i & valid_o
//  valid_o      out  1      code_o holds an undelivered code
//  code_o       out  2      encoded request index
//  pending_o    out  4      queued, not-yet-emitted requests
//  merge_cnt_o  out  CNT_W  count of requests merged into an already-pending bit
// BEHAVIOUR
//  Reset (async, immediate): pending=0, valid_o=0, code_o=0, merge_cnt=0, req history=0, FSM=IDLE, rr pointer=0.
//  Reset mid-handshake: queued and presented codes discarded; no delivery after release.
//  Capture: cap = EDGE_MODE ? (req_i & ~req_q) : req_i; pending <= (pending & ~clr) | cap each cycle.
//  Merge: cap bit k while pending[k] already set and not cleared this cycle -> merge_cnt+1, saturate at 2^CNT_W-1.
//  Capture and clear of the same bit in one cycle: set wins (bit stays pending), not counted as merge.
//  Selection uses registered pending only (not same-cycle cap). Fixed priority: lowest index wins.
//  FSM IDLE: pending!=0 -> code_o<=winner, valid_o<=1, clr=onehot(winner), go HOLD; else stay, valid_o=0.
//  FSM HOLD: valid_o and code_o stable while ready_i=0.
//   ready_i=1 and (pending & ~...)!=0 -> load next winner same cycle, valid_o stays 1 (back-to-back, 1 code/cycle).
//   ready_i=1 and pending==0 -> valid_o<=0, go IDLE.
//  Latency: req_i edge at cycle n -> pending at n+1 -> valid_o at n+2 (queue empty, FSM IDLE).
//  All 4 lines at once: codes emitted in priority order on 4 consecutive handshakes.
//  pending_o reflects register; merge_cnt_o never wraps.
// CONFIGURATION
//  ROUND_RR_EN defined: rotating priority; search starts at rr pointer, after each grant ptr <= winner+1 (mod 4).
//  ROUND_RR_EN undefined: fixed priority, bit 0 highest; no pointer flop synthesised.
// STRUCTURE
//  Package enc_pkg: REQ_W, CODE_W=2, state enum {IDLE, HOLD}, function onehot(code).
//  Sub-module prio_sel_4: combinational 4-bit selector, inputs vec+base, outputs any, idx[1:0]; base tied 0 without ROUND_RR_EN.
//  Top holds req history, pending, FSM, output regs, merge counter.
// TESTING
//  Reset asserted mid-HOLD with pending=4'b1010 -> valid_o=0, pending_o=0 immediately; nothing emitted after release.
//  Single pulse req_i=4'b0100, ready_i=1 -> valid_o high 2 cycles after edge, code_o=2, one handshake, back to IDLE.
//  req_i=4'b1111 one cycle, ready_i=1 -> codes 0,1,2,3 on 4 consecutive cycles (ROUND_RR_EN off).
//  ready_i=0 for 10 cycles with code 1 presented -> valid_o, code_o unchanged; then ready_i=1 -> delivered once.
//  req_i[2] re-pulsed 300 times while pending[2] held -> merge_cnt_o saturates at 255.
//  ROUND_RR_EN: grant 1, then req_i=4'b0011 -> code 1 not first; order 0? no: ptr=2 -> codes 0 then 1 only after ptr wraps; expect 0,1.

Source files
------------

// File: rtl/req_4_2_encoder_pkg.sv
// -----------------------------------------------------------------------------
// enc_pkg
//   Shared definitions for the 4->2 request encoder slice.
//   - REQ_W / CODE_W : request-vector width and encoded-index width
//   - state_e        : handshake FSM states (IDLE, HOLD)
//   - onehot()       : expand a 2-bit code into its 4-bit request mask
// -----------------------------------------------------------------------------
package enc_pkg;

  localparam int REQ_W  = 4;
  localparam int CODE_W = 2;

  // IDLE: nothing presented on the output stream.
  // HOLD: a code is presented and waits for the consumer.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic logic [REQ_W-1:0] onehot(input logic [CODE_W-1:0] code);
    logic [REQ_W-1:0] mask;
    mask       = '0;
    mask[code] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/req_4_2_encoder_prio_sel_4.sv
// -----------------------------------------------------------------------------
// prio_sel_4
//   Combinational 4-bit priority selector with a movable starting point.
//   The search begins at index base_i and walks upward, wrapping modulo 4;
//   the first set bit wins. With base_i = 0 this is plain lowest-index-wins.
//
// Ports
//   vec_i   in  4  candidate request bits
//   base_i  in  2  index searched first
//   any_o   out 1  at least one bit of vec_i is set
//   idx_o   out 2  index of the winning bit (0 when any_o = 0)
// -----------------------------------------------------------------------------
module prio_sel_4
  import enc_pkg::*;
(
  input  logic [REQ_W-1:0]  vec_i,
  input  logic [CODE_W-1:0] base_i,
  output logic              any_o,
  output logic [CODE_W-1:0] idx_o
);

  logic [REQ_W-1:0]  rot;
  logic [CODE_W-1:0] off;

  always_comb begin
    // rot[k] is the candidate k positions after base_i; 2-bit addition wraps
    // modulo 4, so the rotation needs no explicit modulo.
    rot = '0;
    for (int k = 0; k < REQ_W; k++) begin
      rot[k] = vec_i[CODE_W'(k) + base_i];
    end

    // Scan from the top down so the lowest rotated position is written last.
    off = '0;
    for (int k = REQ_W - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = CODE_W'(k);
      end
    end

    any_o = |vec_i;
    idx_o = off + base_i;
  end

endmodule

// File: rtl/req_4_2_encoder.sv
// -----------------------------------------------------------------------------
// req_4_2_encoder
//   Inverse of the 2->4 decoder: request lines are captured into a pending
//   queue (one bit per code) and drained as 2-bit codes on a registered
//   valid/ready stream, one code per accepted handshake.
//
// Parameters
//   CNT_W      width of the saturating merge counter
//   EDGE_MODE  1: capture on rising edge of req_i; 0: capture while high
//
// Optional build macro
//   ROUND_RR_EN  rotating priority: the search starts at a pointer that moves
//                to winner+1 after every grant. Undefined: bit 0 always has
//                the highest priority and no pointer register exists.
//
// Ports
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous, active-high reset
//   req_i        in   4      request lines, bit k -> code k
//   ready_i      in   1      consumer ready
//   valid_o      out  1      code_o holds an undelivered code
//   code_o       out  2      encoded request index
//   pending_o    out  4      queued, not-yet-emitted requests
//   merge_cnt_o  out  CNT_W  requests folded into an already-pending bit
//   state_o      out  1      FSM state, for observation only
//
// Output stream handshake: a code transfers on a rising edge where
// valid_o & ready_i are both 1. While valid_o = 1 and ready_i = 0, code_o and
// valid_o are held unchanged. valid_o never depends combinationally on
// ready_i; both valid_o and code_o come straight from registers.
// -----------------------------------------------------------------------------
module req_4_2_encoder
  import enc_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQ_W-1:0]  req_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [CODE_W-1:0] code_o,
  output logic [REQ_W-1:0]  pending_o,
  output logic [CNT_W-1:0]  merge_cnt_o,
  output state_e            state_o
);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [REQ_W-1:0]  req_q,       req_d;
  logic [REQ_W-1:0]  pending_q,   pending_d;
  state_e            state_q,     state_d;
  logic              valid_q,     valid_d;
  logic [CODE_W-1:0] code_q,      code_d;
  logic [CNT_W-1:0]  merge_cnt_q, merge_cnt_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [REQ_W-1:0]  cap;
  logic [REQ_W-1:0]  clr;
  logic [REQ_W-1:0]  merge_bits;
  logic [2:0]        merge_n;
  logic [CNT_W:0]    merge_sum;
  logic              grant;
  logic              sel_any;
  logic [CODE_W-1:0] sel_idx;
  logic [CODE_W-1:0] sel_base;

`ifdef ROUND_RR_EN
  logic [CODE_W-1:0] rr_ptr_q, rr_ptr_d;
  assign sel_base = rr_ptr_q;
`else
  assign sel_base = '0;
`endif

  // Selection looks only at the registered queue, so a request captured this
  // cycle can be granted at the earliest on the following cycle.
  prio_sel_4 u_sel (
    .vec_i  (pending_q),
    .base_i (sel_base),
    .any_o  (sel_any),
    .idx_o  (sel_idx)
  );

  // ---------------------------------------------------------------------------
  // Capture
  // ---------------------------------------------------------------------------
  always_comb begin
    req_d = req_i;
    if (EDGE_MODE) begin
      cap = req_i & ~req_q;
    end else begin
      cap = req_i;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and output-register loading
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    code_d  = code_q;
    grant   = 1'b0;
    clr     = '0;
`ifdef ROUND_RR_EN
    rr_ptr_d = rr_ptr_q;
`endif

    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (sel_any) begin
          grant   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Presented code is retired on ready_i; the next winner, if any,
        // replaces it in the same cycle so the stream runs one code/cycle.
        if (ready_i) begin
          if (sel_any) begin
            grant = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (grant) begin
      valid_d = 1'b1;
      code_d  = sel_idx;
      clr     = onehot(sel_idx);
`ifdef ROUND_RR_EN
      rr_ptr_d = sel_idx + CODE_W'(1);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Pending queue and merge counter
  // ---------------------------------------------------------------------------
  always_comb begin
    // Set wins over clear: a bit captured in its own grant cycle stays
    // pending and is a fresh request, not a merge.
    pending_d  = (pending_q & ~clr) | cap;
    merge_bits = cap & pending_q & ~clr;

    merge_n = '0;
    for (int k = 0; k < REQ_W; k++) begin
      merge_n = merge_n + {2'b00, merge_bits[k]};
    end

    // One extra bit detects overflow so the counter pins at all-ones.
    merge_sum = {1'b0, merge_cnt_q} + {{(CNT_W-2){1'b0}}, merge_n};
    if (merge_sum[CNT_W]) begin
      merge_cnt_d = '1;
    end else begin
      merge_cnt_d = merge_sum[CNT_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q       <= '0;
      pending_q   <= '0;
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      code_q      <= '0;
      merge_cnt_q <= '0;
    end else begin
      req_q       <= req_d;
      pending_q   <= pending_d;
      state_q     <= state_d;
      valid_q     <= valid_d;
      code_q      <= code_d;
      merge_cnt_q <= merge_cnt_d;
    end
  end

`ifdef ROUND_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign valid_o     = valid_q;
  assign code_o      = code_q;
  assign pending_o   = pending_q;
  assign merge_cnt_o = merge_cnt_q;
  assign state_o     = state_q;

endmodule
